// File: rtl/intr_ctrl.sv
// Interrupt controller for IO0..IO(NDEV-1): fast/normal arbitration, CPU request/acknowledge
// handshake, one-hot int_ack pulse and io_enable, with one level of fast-over-normal nesting.
module intr_ctrl #(
   parameter int NDEV    = 3,
   parameter int ACK_CYC = 2
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [NDEV-1:0] fintr,
   input  logic [NDEV-1:0] intr,
   input  logic            cpu_inta,
   input  logic            cpu_reti,
   output logic            cpu_fint,
   output logic            cpu_int,
   output logic [NDEV-1:0] int_ack,
   output logic [NDEV-1:0] io_enable,
   output logic [2:0]      vector,
   output logic            busy
);

   typedef enum logic [2:0] {IDLE, REQ, ACK, SVC, NREQ, NACK, NSVC} state_t;
   localparam int CW = (ACK_CYC > 1) ? $clog2(ACK_CYC) : 1;

   state_t        state_q, state_d;
   logic [2:0]    win_q, win_d;   // {fast, id} currently offered to the CPU
   logic [2:0]    cur_q, cur_d;   // {fast, id} currently in service
   logic [1:0]    stk_q, stk_d;   // preempted normal device
   logic [2:0]    vec_q, vec_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          any_f, any_n, any_req;
   logic [1:0]    id_f, id_n;
   logic [2:0]    arb_all;
   logic [NDEV-1:0] cur_oh;

   // Scan from the top index down so the lowest requesting index is the one left standing.
   always_comb begin
      any_f = 1'b0;
      any_n = 1'b0;
      id_f  = '0;
      id_n  = '0;
      for (int i = NDEV - 1; i >= 0; i--) begin
         if (fintr[i]) begin
            any_f = 1'b1;
            id_f  = 2'(i);
         end
         if (intr[i]) begin
            any_n = 1'b1;
            id_n  = 2'(i);
         end
      end
   end

   assign any_req = any_f | any_n;
   assign arb_all = any_f ? {1'b1, id_f} : {1'b0, id_n};

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      cur_d   = cur_q;
      stk_d   = stk_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               win_d   = arb_all;
               state_d = REQ;
            end
         end
         REQ: begin
            if (cpu_inta) begin
               vec_d   = win_q;
               cur_d   = win_q;
               cnt_d   = '0;
               state_d = ACK;
            end else if (any_req) begin
               win_d = arb_all;
            end else begin
               state_d = IDLE;
            end
         end
         ACK, NACK: begin
            if (cnt_q == CW'(ACK_CYC - 1)) state_d = (state_q == ACK) ? SVC : NSVC;
            else                          cnt_d   = cnt_q + 1'b1;
         end
         SVC: begin
            if (cpu_reti) begin
               state_d = IDLE;
            end else if (!cur_q[2] && any_f) begin
               stk_d   = cur_q[1:0];
               win_d   = {1'b1, id_f};
               state_d = NREQ;
            end
         end
         NREQ: begin
            // Only fast requests may preempt; the normal device keeps io_enable meanwhile.
            if (cpu_inta) begin
               vec_d   = win_q;
               cur_d   = win_q;
               cnt_d   = '0;
               state_d = NACK;
            end else if (any_f) begin
               win_d = {1'b1, id_f};
            end else begin
               state_d = SVC;
            end
         end
         NSVC: begin
            if (cpu_reti) begin
               cur_d   = {1'b0, stk_q};
               state_d = SVC;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples the
   // pre-edge values of the others.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         win_q   <= '0;
         cur_q   <= '0;
         stk_q   <= '0;
         vec_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         cur_q   <= cur_d;
         stk_q   <= stk_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode registered state only, so an async reset clears them at once.
   assign cur_oh    = NDEV'(1) << cur_q[1:0];
   assign cpu_fint  = ((state_q == REQ) && win_q[2]) || (state_q == NREQ);
   assign cpu_int   = (state_q == REQ) && !win_q[2];
   assign busy      = (state_q == ACK) || (state_q == SVC) || (state_q == NREQ) ||
                      (state_q == NACK) || (state_q == NSVC);
   assign io_enable = busy ? cur_oh : '0;
   assign int_ack   = ((state_q == ACK) || (state_q == NACK)) ? cur_oh : '0;
   assign vector    = vec_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed scenarios plus random traffic, all compared
// against a stack-based behavioural model of the interrupt protocol.
module tb_intr_ctrl;

   localparam int NDEV    = 3;
   localparam int ACK_CYC = 2;

   logic            Clk = 1'b0;
   logic            Reset = 1'b1;
   logic [NDEV-1:0] fintr = '0;
   logic [NDEV-1:0] intr = '0;
   logic            cpu_inta = 1'b0;
   logic            cpu_reti = 1'b0;
   logic            cpu_fint, cpu_int, busy;
   logic [NDEV-1:0] int_ack, io_enable;
   logic [2:0]      vector;

   int n_cmp = 0;
   int n_bad = 0;

   intr_ctrl #(.NDEV(NDEV), .ACK_CYC(ACK_CYC)) dut (
      .Clk(Clk), .Reset(Reset), .fintr(fintr), .intr(intr),
      .cpu_inta(cpu_inta), .cpu_reti(cpu_reti), .cpu_fint(cpu_fint), .cpu_int(cpu_int),
      .int_ack(int_ack), .io_enable(io_enable), .vector(vector), .busy(busy)
   );

   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Model: interrupts in service form a stack of codes (fast*4 + id); one pending offer to
   // the CPU; a countdown of remaining acknowledge cycles for the top of the stack.
   int m_stack[$];
   bit m_req;
   int m_code;
   int m_ack_left;
   int m_vec;

   function automatic int best(bit fast_only, logic [NDEV-1:0] f, logic [NDEV-1:0] n);
      for (int i = 0; i < NDEV; i++) if (f[i]) return 4 + i;
      if (!fast_only) for (int i = 0; i < NDEV; i++) if (n[i]) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_stack.delete();
      m_req      = 1'b0;
      m_code     = 0;
      m_ack_left = 0;
      m_vec      = 0;
   endtask

   task automatic model_step();
      int b;
      if (m_ack_left > 0) begin
         m_ack_left--;
      end else if (m_req) begin
         if (cpu_inta) begin
            m_vec = m_code;
            m_stack.push_back(m_code);
            m_ack_left = ACK_CYC;
            m_req = 1'b0;
         end else begin
            b = best(m_stack.size() != 0, fintr, intr);
            if (b < 0) m_req = 1'b0;
            else       m_code = b;
         end
      end else if (m_stack.size() != 0) begin
         if (cpu_reti) begin
            void'(m_stack.pop_back());
         end else if (m_stack.size() == 1 && m_stack[0] < 4 && fintr != '0) begin
            m_req  = 1'b1;
            m_code = best(1'b1, fintr, intr);
         end
      end else begin
         b = best(1'b0, fintr, intr);
         if (b >= 0) begin
            m_req  = 1'b1;
            m_code = b;
         end
      end
   endtask

   function automatic logic [11:0] exp_bundle();
      logic [2:0] ack, en;
      int top;
      ack = '0;
      en  = '0;
      if (m_stack.size() != 0) begin
         top = m_stack[$] % 4;
         en  = 3'(1 << top);
         if (m_ack_left > 0) ack = en;
      end
      return {m_req && m_code >= 4, m_req && m_code < 4, ack, en, 3'(m_vec), m_stack.size() != 0};
   endfunction

   function automatic logic [11:0] obs();
      return {cpu_fint, cpu_int, int_ack, io_enable, vector, busy};
   endfunction

   // Advance one clock; inputs were set at the preceding negedge and are stable at posedge.
   task automatic tick();
      @(posedge Clk);
      if (!Reset) model_step();
      @(negedge Clk);
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      n_cmp++;
      if (obs() !== 12'h000) begin
         n_bad++;
         $display("FAIL reset_state: got %h want 000", obs());
      end
      tick();
      n_cmp++;
      if (obs() !== exp_bundle()) begin
         n_bad++;
         $display("FAIL reset_idle: got %h want %h", obs(), exp_bundle());
      end
   endtask

   task automatic test_single_normal();
      int cy;
      for (int c = 1; c <= 11; c++) begin
         intr     = (c < 5) ? 3'b010 : 3'b000;
         cpu_inta = (c == 5);
         cpu_reti = (c == 10);
         tick();
         cy = c + 1;
         n_cmp++;
         if (obs() !== exp_bundle()) begin
            n_bad++;
            $display("FAIL single_model cy%0d: got %h want %h", cy, obs(), exp_bundle());
         end
         if (cy == 2) begin
            n_cmp++;
            if (cpu_int !== 1'b1) begin
               n_bad++;
               $display("FAIL single_cpu_int: got %b want 1", cpu_int);
            end
         end
         if (cy == 6 || cy == 7) begin
            n_cmp++;
            if (int_ack !== 3'b010 || vector !== 3'b001) begin
               n_bad++;
               $display("FAIL single_ack cy%0d: got ack=%b vec=%b want 010/001", cy, int_ack, vector);
            end
         end
         if (cy == 10 || cy == 11) begin
            n_cmp++;
            if (io_enable !== ((cy == 10) ? 3'b010 : 3'b000)) begin
               n_bad++;
               $display("FAIL single_enable cy%0d: got %b", cy, io_enable);
            end
         end
      end
      cpu_inta = 1'b0;
      cpu_reti = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_priority();
      int cy;
      for (int c = 1; c <= 12; c++) begin
         fintr    = (c < 3) ? 3'b100 : 3'b000;
         intr     = (c < 11) ? 3'b001 : 3'b000;
         cpu_inta = (c == 3);
         cpu_reti = (c == 7);
         tick();
         cy = c + 1;
         n_cmp++;
         if (obs() !== exp_bundle()) begin
            n_bad++;
            $display("FAIL prio_model cy%0d: got %h want %h", cy, obs(), exp_bundle());
         end
         if (cy == 2) begin
            n_cmp++;
            if ({cpu_fint, cpu_int} !== 2'b10) begin
               n_bad++;
               $display("FAIL prio_lines: got fint=%b int=%b want 1/0", cpu_fint, cpu_int);
            end
         end
         if (cy == 4) begin
            n_cmp++;
            if (int_ack !== 3'b100 || vector !== 3'b110) begin
               n_bad++;
               $display("FAIL prio_ack: got ack=%b vec=%b want 100/110", int_ack, vector);
            end
         end
         if (cy == 9) begin
            n_cmp++;
            if ({cpu_fint, cpu_int} !== 2'b01) begin
               n_bad++;
               $display("FAIL prio_held_normal: got fint=%b int=%b want 0/1", cpu_fint, cpu_int);
            end
         end
      end
      cpu_inta = 1'b0;
      cpu_reti = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_nesting();
      int cy;
      for (int c = 1; c <= 16; c++) begin
         intr     = (c < 3) ? 3'b010 : 3'b000;
         fintr    = (c == 7 || c == 8) ? 3'b100 : 3'b000;
         cpu_inta = (c == 3 || c == 9);
         cpu_reti = (c == 13 || c == 15);
         tick();
         cy = c + 1;
         n_cmp++;
         if (obs() !== exp_bundle()) begin
            n_bad++;
            $display("FAIL nest_model cy%0d: got %h want %h", cy, obs(), exp_bundle());
         end
         if (cy == 8) begin
            n_cmp++;
            if ({cpu_fint, cpu_int, io_enable} !== 5'b10010) begin
               n_bad++;
               $display("FAIL nest_req: got fint=%b int=%b en=%b", cpu_fint, cpu_int, io_enable);
            end
         end
         if (cy == 10) begin
            n_cmp++;
            if (io_enable !== 3'b100 || int_ack !== 3'b100 || vector !== 3'b110) begin
               n_bad++;
               $display("FAIL nest_ack: got en=%b ack=%b vec=%b", io_enable, int_ack, vector);
            end
         end
         if (cy == 14) begin
            n_cmp++;
            if (io_enable !== 3'b010 || busy !== 1'b1 || vector !== 3'b110) begin
               n_bad++;
               $display("FAIL nest_restore: got en=%b busy=%b vec=%b", io_enable, busy, vector);
            end
         end
         if (cy == 16) begin
            n_cmp++;
            if (busy !== 1'b0 || io_enable !== 3'b000) begin
               n_bad++;
               $display("FAIL nest_done: got busy=%b en=%b want 0/000", busy, io_enable);
            end
         end
      end
      cpu_inta = 1'b0;
      cpu_reti = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_reraise();
      int pulses = 0;
      int w;
      fintr = 3'b100;
      for (int k = 0; k < 4; k++) begin
         w = 0;
         while (cpu_fint !== 1'b1 && w < 8) begin
            tick();
            w++;
         end
         n_cmp++;
         if (cpu_fint !== 1'b1) begin
            n_bad++;
            $display("FAIL reraise_wait%0d: got cpu_fint=%b want 1", k, cpu_fint);
         end
         cpu_inta = 1'b1;
         @(posedge Clk);
         fintr[2] = 1'b0;
         fintr[2] = 1'b1;
         model_step();
         @(negedge Clk);
         cpu_inta = 1'b0;
         if (int_ack === 3'b100 && vector === 3'b110) pulses++;
         for (int j = 0; j < 3; j++) begin
            n_cmp++;
            if (obs() !== exp_bundle()) begin
               n_bad++;
               $display("FAIL reraise_model%0d.%0d: got %h want %h", k, j, obs(), exp_bundle());
            end
            cpu_reti = (j == 2);
            tick();
         end
         cpu_reti = 1'b0;
      end
      fintr = '0;
      repeat (3) tick();
      n_cmp++;
      if (pulses !== 4) begin
         n_bad++;
         $display("FAIL reraise_pulses: got %0d want 4", pulses);
      end
   endtask

   task automatic test_withdrawn();
      int cy;
      for (int c = 1; c <= 6; c++) begin
         intr     = (c == 1) ? 3'b001 : 3'b000;
         cpu_inta = (c == 4);
         tick();
         cy = c + 1;
         n_cmp++;
         if (obs() !== exp_bundle()) begin
            n_bad++;
            $display("FAIL withdraw_model cy%0d: got %h want %h", cy, obs(), exp_bundle());
         end
         if (cy == 2 || cy == 3) begin
            n_cmp++;
            if (cpu_int !== (cy == 2)) begin
               n_bad++;
               $display("FAIL withdraw_cpu_int cy%0d: got %b", cy, cpu_int);
            end
         end
         if (cy >= 5) begin
            n_cmp++;
            if (int_ack !== 3'b000 || busy !== 1'b0) begin
               n_bad++;
               $display("FAIL withdraw_late_inta cy%0d: got ack=%b busy=%b want 000/0", cy, int_ack, busy);
            end
         end
      end
      cpu_inta = 1'b0;
   endtask

   task automatic test_reset_mid_ack();
      intr = 3'b010;
      tick();
      intr     = 3'b000;
      cpu_inta = 1'b1;
      tick();
      cpu_inta = 1'b0;
      n_cmp++;
      if (int_ack !== 3'b010) begin
         n_bad++;
         $display("FAIL rst_pre_ack: got %b want 010", int_ack);
      end
      #2 Reset = 1'b1;
      #1;
      model_reset();
      n_cmp++;
      if (obs() !== 12'h000) begin
         n_bad++;
         $display("FAIL rst_mid_ack: got %h want 000", obs());
      end
      @(negedge Clk);
      Reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_cmp++;
         if (obs() !== 12'h000 || obs() !== exp_bundle()) begin
            n_bad++;
            $display("FAIL rst_after%0d: got %h want 000", c, obs());
         end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            fintr = NDEV'($urandom & $urandom & $urandom);
            intr  = NDEV'($urandom & $urandom);
         end
         cpu_inta = ($urandom_range(0, 3) == 0);
         cpu_reti = ($urandom_range(0, 4) == 0);
         tick();
         n_cmp++;
         if (obs() !== exp_bundle()) begin
            n_bad++;
            $display("FAIL random c%0d: got %h want %h", c, obs(), exp_bundle());
         end
      end
      fintr    = '0;
      intr     = '0;
      cpu_inta = 1'b0;
      cpu_reti = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_normal();
      test_priority();
      test_nesting();
      test_reraise();
      test_withdrawn();
      test_reset_mid_ack();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
